// File: rtl/floor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : floor_pkg
// Description : Shared constants and types for the floor / player physics
//               pipeline: floor geometry, screen limits, the physics FSM
//               state encoding and the "no supporting floor" marker.
// Revision    : 1.0  initial release
// ============================================================================
package floor_pkg;

  localparam int NUM_FLOORS = 5;
  localparam int FLOOR_W    = 90;
  localparam int FLOOR_H    = 20;

  localparam int SCREEN_W   = 640;
  localparam int Y_MIN      = 0;
  localparam int Y_MAX      = 479;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    UPDATE = 2'd2,
    DEAD   = 2'd3
  } physics_state_t;

  // landed_idx value meaning "airborne"
  localparam logic [2:0] NO_FLOOR = 3'd7;

endpackage
`default_nettype wire

// File: rtl/bcd_score_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_score_counter
// Description : Two-digit BCD score counter. Increments by one on each cycle
//               that inc is high; ones digit wraps 9->0 carrying into tens;
//               the count saturates at 99.
// Ports       : Clk    - system clock
//               Reset  - synchronous active-high reset (score -> 00)
//               inc    - single-cycle increment request
//               score1 - BCD tens digit
//               score0 - BCD ones digit
// Revision    : 1.0  initial release
// ============================================================================
module bcd_score_counter (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       inc,
  output logic [3:0] score1,
  output logic [3:0] score0
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       at_max;

  assign at_max = (tens_q == 4'd9) && (ones_q == 4'd9);

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (inc && !at_max) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign score1 = tens_q;
  assign score0 = ones_q;

endmodule
`default_nettype wire

// File: rtl/player_floor_physics.sv
`default_nettype none
// ============================================================================
// Module      : player_floor_physics
// Description : Per-frame player physics and scoring. On each frame strobe
//               the five floors are scanned (one per clock) for support under
//               the player, then a single update cycle applies horizontal
//               movement, gravity or snap-to-floor, scoring and death.
//               Outputs change 7 clocks after the frame_clk rising edge.
// Ports       : Clk, Reset          - clock, synchronous active-high reset
//               frame_clk           - frame strobe, acted on at rising edge
//               key_left, key_right - held direction keys
//               floor_x, floor_y    - left / top edge of each live floor
//               player_x, player_y  - player left / top edge
//               score1, score0      - BCD score tens / ones
//               landed_idx          - supporting floor index, 7 = airborne
//               game_over           - sticky death flag
// Revision    : 1.0  initial release
// ============================================================================
module player_floor_physics #(
  parameter int PLAYER_SIZE = 16,
  parameter int FALL_STEP   = 3,
  parameter int X_STEP      = 2,
  parameter int PX_INIT     = 312,
  parameter int PY_INIT     = 100,
  parameter int SCREEN_W    = floor_pkg::SCREEN_W,
  parameter int Y_MIN       = floor_pkg::Y_MIN,
  parameter int Y_MAX       = floor_pkg::Y_MAX
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       key_left,
  input  logic       key_right,
  input  logic [9:0] floor_x [floor_pkg::NUM_FLOORS],
  input  logic [9:0] floor_y [floor_pkg::NUM_FLOORS],
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic [3:0] score1,
  output logic [3:0] score0,
  output logic [2:0] landed_idx,
  output logic       game_over
);

  import floor_pkg::*;

  localparam logic [10:0]        c_size11    = 11'(PLAYER_SIZE);
  localparam logic [10:0]        c_floor_w11 = 11'(FLOOR_W);
  localparam logic [10:0]        c_x_step11  = 11'(X_STEP);
  localparam logic [10:0]        c_x_max11   = 11'(SCREEN_W - PLAYER_SIZE);
  localparam logic [9:0]         c_x_max10   = 10'(SCREEN_W - PLAYER_SIZE);
  localparam logic signed [11:0] c_size12    = 12'(PLAYER_SIZE);
  localparam logic signed [11:0] c_fall12    = 12'(FALL_STEP);
  localparam logic signed [11:0] c_y_min12   = 12'(Y_MIN);
  localparam logic signed [11:0] c_y_max12   = 12'(Y_MAX);
  localparam logic [2:0]         c_last_idx  = 3'(NUM_FLOORS - 1);

  physics_state_t state_q, state_d;

  logic       frame_q;
  logic       frame_edge;
  logic [2:0] scan_idx_q, scan_idx_d;
  logic       hit_found_q, hit_found_d;
  logic [2:0] hit_idx_q, hit_idx_d;
  logic [9:0] px_q, px_d;
  logic [9:0] py_q, py_d;
  logic [2:0] landed_q, landed_d;
  logic       game_over_q, game_over_d;
  logic       score_inc;

  assign frame_edge = frame_clk & ~frame_q;

  // --------------------------------------------------------------------------
  // Support test for the floor currently addressed by the scan index.
  // Everything is widened so that sums near 1023 cannot wrap.
  // --------------------------------------------------------------------------
  logic [9:0]         scan_fx, scan_fy;
  logic [10:0]        px_ext, fx_ext, bottom;
  logic signed [11:0] catch_lo;
  logic               overlap, in_catch, supported;

  assign scan_fx   = floor_x[scan_idx_q];
  assign scan_fy   = floor_y[scan_idx_q];
  assign px_ext    = {1'b0, px_q};
  assign fx_ext    = {1'b0, scan_fx};
  assign bottom    = {1'b0, py_q} + c_size11;
  assign overlap   = ((px_ext + c_size11) > fx_ext) && (px_ext < (fx_ext + c_floor_w11));
  // floor_y - FALL_STEP may go negative for floors near the top
  assign catch_lo  = $signed({2'b00, scan_fy}) - c_fall12;
  assign in_catch  = ($signed({1'b0, bottom}) >= catch_lo) && (bottom <= ({1'b0, scan_fy} + 11'd1));
  assign supported = overlap && in_catch;

  // --------------------------------------------------------------------------
  // Candidate position for the update cycle
  // --------------------------------------------------------------------------
  logic [9:0]         land_fy;
  logic signed [11:0] y_new;
  logic [9:0]         x_new;
  logic               dies;

  assign land_fy = floor_y[hit_idx_q];
  assign y_new   = hit_found_q ? ($signed({2'b00, land_fy}) - c_size12)
                               : ($signed({2'b00, py_q}) + c_fall12);
  assign dies    = (y_new <= c_y_min12) || ((y_new + c_size12) >= c_y_max12);

  always_comb begin
    x_new = px_q;
    if (key_left && !key_right) begin
      x_new = (px_ext < c_x_step11) ? 10'd0 : 10'(px_ext - c_x_step11);
    end else if (key_right && !key_left) begin
      x_new = ((px_ext + c_x_step11) > c_x_max11) ? c_x_max10 : 10'(px_ext + c_x_step11);
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_edge) state_d = SCAN;
      SCAN:    if (scan_idx_q == c_last_idx) state_d = UPDATE;
      UPDATE:  state_d = dies ? DEAD : IDLE;
      DEAD:    state_d = DEAD;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next values per state
  // --------------------------------------------------------------------------
  always_comb begin
    scan_idx_d  = scan_idx_q;
    hit_found_d = hit_found_q;
    hit_idx_d   = hit_idx_q;
    px_d        = px_q;
    py_d        = py_q;
    landed_d    = landed_q;
    game_over_d = game_over_q;
    score_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_edge) begin
          scan_idx_d  = 3'd0;
          hit_found_d = 1'b0;
          hit_idx_d   = NO_FLOOR;
        end
      end
      SCAN: begin
        scan_idx_d = scan_idx_q + 3'd1;
        // lowest index wins: once latched, later hits are ignored
        if (!hit_found_q && supported) begin
          hit_found_d = 1'b1;
          hit_idx_d   = scan_idx_q;
        end
      end
      UPDATE: begin
        px_d        = x_new;
        py_d        = y_new[9:0];
        landed_d    = hit_found_q ? hit_idx_q : NO_FLOOR;
        game_over_d = dies;
        // only a landing on a floor other than the current one scores
        score_inc   = hit_found_q && (hit_idx_q != landed_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      // reset to 1 so a frame_clk already high at reset release is not an edge
      frame_q     <= 1'b1;
      scan_idx_q  <= 3'd0;
      hit_found_q <= 1'b0;
      hit_idx_q   <= NO_FLOOR;
      px_q        <= 10'(PX_INIT);
      py_q        <= 10'(PY_INIT);
      landed_q    <= NO_FLOOR;
      game_over_q <= 1'b0;
    end else begin
      frame_q     <= frame_clk;
      scan_idx_q  <= scan_idx_d;
      hit_found_q <= hit_found_d;
      hit_idx_q   <= hit_idx_d;
      px_q        <= px_d;
      py_q        <= py_d;
      landed_q    <= landed_d;
      game_over_q <= game_over_d;
    end
  end

  bcd_score_counter u_score (
    .Clk    (Clk),
    .Reset  (Reset),
    .inc    (score_inc),
    .score1 (score1),
    .score0 (score0)
  );

  assign player_x   = px_q;
  assign player_y   = py_q;
  assign landed_idx = landed_q;
  assign game_over  = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_player_floor_physics.sv
`default_nettype none
// ============================================================================
// Module      : tb_player_floor_physics
// Description : Directed testbench for player_floor_physics with
//               hand-computed expected values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_player_floor_physics;

  import floor_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       key_left = 1'b0;
  logic       key_right = 1'b0;
  logic [9:0] floor_x [NUM_FLOORS];
  logic [9:0] floor_y [NUM_FLOORS];
  logic [9:0] player_x, player_y;
  logic [3:0] score1, score0;
  logic [2:0] landed_idx;
  logic       game_over;

  int n_checks = 0;
  int n_fail   = 0;
  int mpx;

  player_floor_physics dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .key_left   (key_left),
    .key_right  (key_right),
    .floor_x    (floor_x),
    .floor_y    (floor_y),
    .player_x   (player_x),
    .player_y   (player_y),
    .score1     (score1),
    .score0     (score0),
    .landed_idx (landed_idx),
    .game_over  (game_over)
  );

  always #10 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic floors_away();
    for (int i = 0; i < NUM_FLOORS; i++) begin
      floor_x[i] = 10'd600;
      floor_y[i] = 10'd300;
    end
  endtask

  task automatic set_floor(input int idx, input int x, input int y);
    floor_x[idx] = 10'(x);
    floor_y[idx] = 10'(y);
  endtask

  task automatic apply_reset();
    @(posedge Clk); #1;
    Reset = 1'b1;
    frame_clk = 1'b0;
    key_left = 1'b0;
    key_right = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic run_frame();
    @(posedge Clk); #1 frame_clk = 1'b1;
    repeat (7) @(posedge Clk);
    #1 frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  initial begin
    floors_away();
    apply_reset();

    // reset values
    check_eq("rst_x", player_x, 312);
    check_eq("rst_y", player_y, 100);
    check_eq("rst_landed", landed_idx, 7);
    check_eq("rst_score", {score1, score0}, 8'h00);
    check_eq("rst_go", game_over, 0);

    // airborne frame with latency check
    @(posedge Clk); #1 frame_clk = 1'b1;
    repeat (6) @(posedge Clk);
    #1 check_eq("lat_before_y", player_y, 100);
    @(posedge Clk);
    #1 check_eq("lat_after_y", player_y, 103);
    frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_eq("air_landed", landed_idx, 7);
    check_eq("air_score", {score1, score0}, 8'h00);

    // landing on floor 2, then same floor again
    apply_reset();
    floors_away();
    set_floor(2, 300, 118);
    run_frame();
    check_eq("land2_y", player_y, 102);
    check_eq("land2_idx", landed_idx, 2);
    check_eq("land2_score", {score1, score0}, 8'h01);
    run_frame();
    check_eq("reland_y", player_y, 102);
    check_eq("reland_score", {score1, score0}, 8'h01);

    // two supporting floors: lowest index wins; fresh landings score
    apply_reset();
    floors_away();
    set_floor(1, 300, 118);
    set_floor(3, 300, 118);
    run_frame();
    check_eq("prio_idx", landed_idx, 1);
    check_eq("prio_score", {score1, score0}, 8'h01);
    set_floor(1, 600, 300);
    run_frame();
    check_eq("move3_idx", landed_idx, 3);
    check_eq("move3_score", {score1, score0}, 8'h02);
    set_floor(1, 300, 118);
    set_floor(3, 600, 300);
    run_frame();
    check_eq("move1_idx", landed_idx, 1);
    check_eq("move1_score", {score1, score0}, 8'h03);

    // horizontal movement and clamping, floor 0 kept under the player
    apply_reset();
    floors_away();
    mpx = 312;
    key_left = 1'b1;
    key_right = 1'b1;
    set_floor(0, mpx, 118);
    run_frame();
    check_eq("both_x", player_x, 312);
    check_eq("both_idx", landed_idx, 0);
    key_right = 1'b0;
    for (int k = 0; k < 155; k++) begin
      set_floor(0, mpx, 118);
      run_frame();
      mpx = (mpx < 2) ? 0 : mpx - 2;
    end
    check_eq("left_x2", player_x, 2);
    set_floor(0, mpx, 118);
    run_frame();
    mpx = 0;
    check_eq("left_x0", player_x, 0);
    set_floor(0, mpx, 118);
    run_frame();
    check_eq("left_clamp0", player_x, 0);
    key_left = 1'b0;
    key_right = 1'b1;
    for (int k = 0; k < 311; k++) begin
      set_floor(0, mpx, 118);
      run_frame();
      mpx = (mpx > 622) ? 624 : mpx + 2;
    end
    check_eq("right_x622", player_x, 622);
    set_floor(0, mpx, 118);
    run_frame();
    mpx = 624;
    check_eq("right_x624", player_x, 624);
    set_floor(0, mpx, 118);
    run_frame();
    check_eq("right_clamp", player_x, 624);
    check_eq("keys_y", player_y, 102);
    check_eq("keys_score", {score1, score0}, 8'h01);
    key_right = 1'b0;

    // score carry and saturation by alternating floors 0 and 1
    apply_reset();
    floors_away();
    for (int f = 1; f <= 100; f++) begin
      if (f % 2 == 1) begin
        set_floor(0, 300, 118);
        set_floor(1, 600, 300);
      end else begin
        set_floor(0, 600, 300);
        set_floor(1, 300, 118);
      end
      run_frame();
      if (f == 10)  check_eq("score_10", {score1, score0}, 8'h10);
      if (f == 98)  check_eq("score_98", {score1, score0}, 8'h98);
      if (f == 99)  check_eq("score_99", {score1, score0}, 8'h99);
      if (f == 100) check_eq("score_sat", {score1, score0}, 8'h99);
    end

    // fall to floor at 478, then fall off and die
    apply_reset();
    floors_away();
    set_floor(0, 300, 478);
    for (int f = 0; f < 120; f++) run_frame();
    check_eq("fall_y460", player_y, 460);
    check_eq("fall_go0", game_over, 0);
    run_frame();
    check_eq("low_land_y", player_y, 462);
    check_eq("low_land_idx", landed_idx, 0);
    check_eq("low_land_go", game_over, 0);
    set_floor(0, 600, 300);
    run_frame();
    check_eq("die_y", player_y, 465);
    check_eq("die_go", game_over, 1);
    check_eq("die_idx", landed_idx, 7);
    key_left = 1'b1;
    set_floor(0, 300, 478);
    run_frame();
    check_eq("dead_x", player_x, 312);
    check_eq("dead_y", player_y, 465);
    check_eq("dead_idx", landed_idx, 7);
    check_eq("dead_score", {score1, score0}, 8'h01);
    check_eq("dead_go", game_over, 1);
    key_left = 1'b0;

    // reset asserted during the third scan cycle
    apply_reset();
    floors_away();
    set_floor(2, 300, 118);
    key_right = 1'b1;
    run_frame();
    check_eq("pre_abort_y", player_y, 102);
    check_eq("pre_abort_x", player_x, 314);
    @(posedge Clk); #1 frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk);
    #1;
    check_eq("abort_x", player_x, 312);
    check_eq("abort_y", player_y, 100);
    check_eq("abort_idx", landed_idx, 7);
    check_eq("abort_score", {score1, score0}, 8'h00);
    check_eq("abort_go", game_over, 0);
    check_eq("abort_state", 32'(dut.state_q), 32'(IDLE));
    Reset = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    check_eq("post_abort_y", player_y, 100);
    check_eq("post_abort_x", player_x, 312);
    key_right = 1'b0;
    frame_clk = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
